// File: rtl/tile_map_if.sv
// Bus between the tile-map engine and its renderer / player-logic clients.
// The client side drives lookups, edits and reloads; the engine answers.
interface tile_map_if #(
  parameter int LVL_W = 2
);
  logic [10:0]      pixelX;
  logic [10:0]      pixelY;
  logic [10:0]      bumpy_x;
  logic [10:0]      bumpy_y;
  logic [LVL_W-1:0] lvl;
  logic             load_req;
  logic             gate;
  logic             collect;
  logic             break_hit;
  logic [2:0]       step_type;
  logic [10:0]      tileTopLeftX;
  logic [10:0]      tileTopLeftY;
  logic [3:0][2:0]  area;
  logic             tele_valid;
  logic [3:0]       tele_x;
  logic [3:0]       tele_y;
  logic [7:0]       coins_left;
  logic             level_clear;
  logic             busy;

  modport master (
    output pixelX, pixelY, bumpy_x, bumpy_y,
    output lvl, load_req, gate, collect, break_hit,
    input  step_type, tileTopLeftX, tileTopLeftY,
    input  area, tele_valid, tele_x, tele_y,
    input  coins_left, level_clear, busy
  );

  modport slave (
    input  pixelX, pixelY, bumpy_x, bumpy_y,
    input  lvl, load_req, gate, collect, break_hit,
    output step_type, tileTopLeftX, tileTopLeftY,
    output area, tele_valid, tele_x, tele_y,
    output coins_left, level_clear, busy
  );
endinterface

// File: rtl/tile_map_engine.sv
// Writable level tile grid loaded from a multi-level ROM, with pixel and
// neighbour lookups, runtime edits, teleport pairing and coin tracking.
module tile_map_engine #(
  parameter int NUM_ROWS   = 7,
  parameter int NUM_COLS   = 10,
  parameter int TILE_SHIFT = 6,
  parameter int NUM_LEVELS = 4,
  parameter int LVL_W      = 2,
  parameter int GATE_ROW   = 6,
  parameter int GATE_COL   = 4
) (
  input  logic     clk,
  input  logic     reset,
  tile_map_if.slave bus
);

  localparam int NCELL = NUM_ROWS * NUM_COLS;
  localparam int IDX_W = $clog2(NCELL);
  localparam int RC_W  = 4;

  localparam logic [2:0] T_FREE  = 3'd0;
  localparam logic [2:0] T_REGU  = 3'd1;
  localparam logic [2:0] T_GATE  = 3'd2;
  localparam logic [2:0] T_COIN  = 3'd3;
  localparam logic [2:0] T_TPORT = 3'd4;
  localparam logic [2:0] T_SPIKE = 3'd5;
  localparam logic [2:0] T_BRAKE = 3'd6;
  localparam logic [2:0] T_RSVD  = 3'd7;

  localparam logic [IDX_W-1:0] GATE_IDX =
    IDX_W'(GATE_ROW * NUM_COLS + GATE_COL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCELL - 1);
  localparam logic [RC_W-1:0]  LAST_COL = RC_W'(NUM_COLS - 1);

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       grid_q [NCELL];
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [RC_W-1:0]  ld_r_q, ld_r_d;
  logic [RC_W-1:0]  ld_c_q, ld_c_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [LVL_W-1:0] lvl_eff;
  logic [7:0]       coins_q, coins_d;
  logic             ta_v_q, ta_v_d, tb_v_q, tb_v_d;
  logic [RC_W-1:0]  ta_r_q, ta_r_d, ta_c_q, ta_c_d;
  logic [RC_W-1:0]  tb_r_q, tb_r_d, tb_c_q, tb_c_d;
  logic             gflag_q, gflag_d;
  logic [2:0]       gsave_q, gsave_d;
  logic             lc_q, lc_d;
  logic [2:0]       step_q, step_d;
  logic [10:0]      tlx_q, tlx_d, tly_q, tly_d;
  logic [3:0][2:0]  area_q, area_d;
  logic             tv_q, tv_d;
  logic [3:0]       tx_q, tx_d, ty_q, ty_d;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [2:0]       wr_data;
  logic [2:0]       rom_t, pix_t, pl_t;
  logic [IDX_W-1:0] pl_idx;
  int               px_r, px_c, pl_r, pl_c;
  logic             on_a, on_b;

  // Level contents; every level has a solid floor on its last row.
  function automatic logic [2:0] rom_tile(
    input logic [LVL_W-1:0] l,
    input int r,
    input int c
  );
    logic [2:0] t;
    t = (r == NUM_ROWS - 1) ? T_REGU : T_FREE;
    case (int'(l))
      0: begin
        if (r == 3 && c >= 1 && c <= 3) t = T_REGU;
        if ((r == 2 && c == 2) || (r == 3 && c == 7)) t = T_COIN;
        if (r == 6 && (c == 1 || c == 7)) t = T_TPORT;
        if (r == 4 && c == 5) t = T_BRAKE;
        if (r == 5 && c == 8) t = T_SPIKE;
      end
      1: begin
        if ((r == 1 && c == 1) || (r == 2 && c == 5)) t = T_COIN;
        if (r == 3 && c == 8) t = T_COIN;
        if (r == 2 && c == 0) t = T_TPORT;
        if (r == 6 && (c == 0 || c == 9)) t = T_TPORT;
        if (r == 4 && c == 4) t = T_BRAKE;
      end
      2: begin
        if (r == 2 && c == 2) t = T_RSVD;
        if (r == 5 && c == 5) t = T_COIN;
      end
      default: ;
    endcase
    return t;
  endfunction

  function automatic logic [2:0] rd(input int r, input int c);
    logic [2:0] t;
    t = T_FREE;
    if (r >= 0 && r < NUM_ROWS && c >= 0 && c < NUM_COLS)
      t = grid_q[IDX_W'(r * NUM_COLS + c)];
    if (t == T_RSVD) t = T_FREE;
    return t;
  endfunction

  assign lvl_eff = (int'(lvl_q) < NUM_LEVELS) ? lvl_q : '0;
  assign rom_t   = rom_tile(lvl_eff, int'(ld_r_q), int'(ld_c_q));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ld_r_d   = ld_r_q;
    ld_c_d   = ld_c_q;
    lvl_d    = lvl_q;
    coins_d  = coins_q;
    ta_v_d   = ta_v_q;
    ta_r_d   = ta_r_q;
    ta_c_d   = ta_c_q;
    tb_v_d   = tb_v_q;
    tb_r_d   = tb_r_q;
    tb_c_d   = tb_c_q;
    gflag_d  = gflag_q;
    gsave_d  = gsave_q;
    lc_d     = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = addr_q;
    wr_data  = rom_t;
    step_d   = T_FREE;
    area_d   = '0;
    tv_d     = 1'b0;
    tx_d     = '0;
    ty_d     = '0;

    px_c   = int'(bus.pixelX >> TILE_SHIFT);
    px_r   = int'(bus.pixelY >> TILE_SHIFT);
    pl_c   = int'(bus.bumpy_x >> TILE_SHIFT);
    pl_r   = int'(bus.bumpy_y >> TILE_SHIFT);
    pix_t  = rd(px_r, px_c);
    pl_t   = rd(pl_r, pl_c);
    pl_idx = IDX_W'(pl_r * NUM_COLS + pl_c);
    tlx_d  = (bus.pixelX >> TILE_SHIFT) << TILE_SHIFT;
    tly_d  = (bus.pixelY >> TILE_SHIFT) << TILE_SHIFT;

    on_a = ta_v_q && tb_v_q &&
           pl_r == int'(ta_r_q) && pl_c == int'(ta_c_q);
    on_b = ta_v_q && tb_v_q &&
           pl_r == int'(tb_r_q) && pl_c == int'(tb_c_q);

    unique case (state_q)
      S_LOAD: begin
        wr_en = 1'b1;
        if (rom_t == T_COIN && coins_q != 8'hFF)
          coins_d = coins_q + 8'd1;
        if (rom_t == T_TPORT) begin
          if (!ta_v_q) begin
            ta_v_d = 1'b1;
            ta_r_d = ld_r_q;
            ta_c_d = ld_c_q;
          end else if (!tb_v_q) begin
            tb_v_d = 1'b1;
            tb_r_d = ld_r_q;
            tb_c_d = ld_c_q;
          end
        end
        if (addr_q == LAST_IDX) begin
          state_d = S_RUN;
          addr_d  = '0;
          ld_r_d  = '0;
          ld_c_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          if (ld_c_q == LAST_COL) begin
            ld_c_d = '0;
            ld_r_d = ld_r_q + 1'b1;
          end else begin
            ld_c_d = ld_c_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        step_d = pix_t;
        area_d = {rd(pl_r + 1, pl_c), rd(pl_r, pl_c + 1),
                  rd(pl_r - 1, pl_c), rd(pl_r, pl_c - 1)};
        if (on_a) begin
          tv_d = 1'b1;
          tx_d = tb_c_q;
          ty_d = tb_r_q;
        end else if (on_b) begin
          tv_d = 1'b1;
          tx_d = ta_c_q;
          ty_d = ta_r_q;
        end
        // One grid write per cycle; losers are dropped, not queued.
        if (bus.load_req) begin
          coins_d = '0;
          ta_v_d  = 1'b0;
          tb_v_d  = 1'b0;
          gflag_d = 1'b0;
          lvl_d   = bus.lvl;
          addr_d  = '0;
          ld_r_d  = '0;
          ld_c_d  = '0;
          state_d = S_LOAD;
        end else if (bus.gate && !gflag_q) begin
          wr_en   = 1'b1;
          wr_idx  = GATE_IDX;
          wr_data = T_GATE;
          gsave_d = grid_q[GATE_IDX];
          gflag_d = 1'b1;
        end else if (!bus.gate && gflag_q) begin
          wr_en   = 1'b1;
          wr_idx  = GATE_IDX;
          wr_data = gsave_q;
          gflag_d = 1'b0;
        end else if (bus.collect && pl_t == T_COIN) begin
          wr_en   = 1'b1;
          wr_idx  = pl_idx;
          wr_data = T_FREE;
          if (coins_q != 8'd0) coins_d = coins_q - 8'd1;
          lc_d = (coins_q == 8'd1);
        end else if (bus.break_hit && pl_t == T_BRAKE) begin
          wr_en   = 1'b1;
          wr_idx  = pl_idx;
          wr_data = T_FREE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
      addr_q  <= '0;
      ld_r_q  <= '0;
      ld_c_q  <= '0;
      lvl_q   <= bus.lvl;
      coins_q <= '0;
      ta_v_q  <= 1'b0;
      ta_r_q  <= '0;
      ta_c_q  <= '0;
      tb_v_q  <= 1'b0;
      tb_r_q  <= '0;
      tb_c_q  <= '0;
      gflag_q <= 1'b0;
      gsave_q <= T_FREE;
      lc_q    <= 1'b0;
      step_q  <= T_FREE;
      tlx_q   <= '0;
      tly_q   <= '0;
      area_q  <= '0;
      tv_q    <= 1'b0;
      tx_q    <= '0;
      ty_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ld_r_q  <= ld_r_d;
      ld_c_q  <= ld_c_d;
      lvl_q   <= lvl_d;
      coins_q <= coins_d;
      ta_v_q  <= ta_v_d;
      ta_r_q  <= ta_r_d;
      ta_c_q  <= ta_c_d;
      tb_v_q  <= tb_v_d;
      tb_r_q  <= tb_r_d;
      tb_c_q  <= tb_c_d;
      gflag_q <= gflag_d;
      gsave_q <= gsave_d;
      lc_q    <= lc_d;
      step_q  <= step_d;
      tlx_q   <= tlx_d;
      tly_q   <= tly_d;
      area_q  <= area_d;
      tv_q    <= tv_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) grid_q[wr_idx] <= wr_data;
  end

  assign bus.step_type    = step_q;
  assign bus.tileTopLeftX = tlx_q;
  assign bus.tileTopLeftY = tly_q;
  assign bus.area         = area_q;
  assign bus.tele_valid   = tv_q;
  assign bus.tele_x       = tx_q;
  assign bus.tele_y       = ty_q;
  assign bus.coins_left   = coins_q;
  assign bus.level_clear  = lc_q;
  assign bus.busy         = (state_q == S_LOAD);

endmodule
